// File: rtl/inst_fetch_queue.sv
// Fetch front end: PC generation, in-order imem requests and a small decode-side FIFO.
// Optional IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module inst_fetch_queue #(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall_fetch,
  input  logic                       stall_decode,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [XLEN-1:0]            imem_rsp_data,
  output logic                       decode_valid,
  output logic [XLEN-1:0]            decode_inst,
  output logic [XLEN-1:0]            decode_pc,
  output logic [$clog2(DEPTH+1)-1:0] queue_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fifo_inst_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [XLEN-1:0] shadow_pc_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   sh_rd_q, sh_rd_d, sh_wr_q, sh_wr_d;
  logic [CW-1:0]   count_q, count_d, inflight_q, inflight_d, drop_cnt_q, drop_cnt_d;
  logic [CW:0]     occupancy;
  logic            req_fire, rsp_accept, rsp_drop;
  logic            fifo_push, fifo_pop, bypass, bypass_take;

  // Outstanding requests that will still land count against FIFO space.
  always_comb begin
    occupancy      = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_cnt_q};
    imem_req_valid = !stall_fetch && !redirect_valid && (occupancy < (CW+1)'(DEPTH)) &&
                     (inflight_q < CW'(DEPTH));
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_accept     = imem_rsp_valid && (inflight_q != '0);
    rsp_drop       = rsp_accept && (drop_cnt_q != '0);
`ifdef IFQ_BYPASS_EN
    bypass         = (count_q == '0) && (drop_cnt_q == '0) && !redirect_valid && rsp_accept;
`else
    bypass         = 1'b0;
`endif
    bypass_take    = bypass && !stall_decode;
    fifo_push      = rsp_accept && !rsp_drop && !redirect_valid && !bypass_take;
    fifo_pop       = (count_q != '0) && !stall_decode && !redirect_valid;
  end

  always_comb begin
    decode_valid = (count_q != '0) || bypass;
    decode_inst  = '0;
    decode_pc    = '0;
    if (count_q != '0) begin
      decode_inst = fifo_inst_q[rd_ptr_q];
      decode_pc   = fifo_pc_q[rd_ptr_q];
    end else if (bypass) begin
      decode_inst = imem_rsp_data;
      decode_pc   = shadow_pc_q[sh_rd_q];
    end
    queue_count = count_q;
  end

  always_comb begin
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q + AW'(fifo_pop);
    wr_ptr_d   = wr_ptr_q + AW'(fifo_push);
    count_d    = count_q + CW'(fifo_push) - CW'(fifo_pop);
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_accept);
    drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
    sh_wr_d    = sh_wr_q + AW'(req_fire);
    sh_rd_d    = sh_rd_q + AW'(rsp_accept);
    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old stream.
      pc_d       = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = inflight_q - CW'(rsp_accept);
    end else if (req_fire) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      sh_rd_q    <= '0;
      sh_wr_q    <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      sh_rd_q    <= sh_rd_d;
      sh_wr_q    <= sh_wr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: decode outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_inst_q[wr_ptr_q] <= imem_rsp_data;
      fifo_pc_q[wr_ptr_q]   <= shadow_pc_q[sh_rd_q];
    end
    if (req_fire) begin
      shadow_pc_q[sh_wr_q] <= pc_q;
    end
  end

endmodule
